prio_arb_mux: RTL and testbench
===============================

PRIO_ARB_MUX -- requirements
Module: prio_arb_mux

Interface
REQ-001 Parameter WIDTH, default 4, sets the bit width of each channel's data.
REQ-002 Parameter NCH, default 4, sets the channel count; the legal range SHALL be 2..16.
REQ-003 Localparam CW SHALL equal clog2(NCH) and set the channel-index width.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NCH  per-channel request, level, one bit per channel.
REQ-007 load  in  NCH  per-channel capture enable for the hold registers.
REQ-008 din  in  NCH*WIDTH  packed channel data; channel i SHALL occupy [i*WIDTH +: WIDTH].
REQ-009 rr_mode  in  1  0 selects fixed priority, 1 selects round-robin.
REQ-010 out_ready  in  1  downstream accept.
REQ-011 out_valid  out  1  output register holds a granted word.
REQ-012 out_data  out  WIDTH  granted word.
REQ-013 out_chan  out  CW  index of the channel that supplied out_data.
REQ-014 grant  out  NCH  one-hot, combinational, high in the cycle the winner is accepted.

Function
REQ-015 Hold register hold[i] SHALL load din slice i on a clock edge where load[i]=1, and SHALL retain its value otherwise.
REQ-016 Arbitration SHALL be enabled ("free") when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-017 Fixed mode: the winner SHALL be the lowest index with req set.
REQ-018 Round-robin mode: the winner SHALL be the first index with req set, searching ptr, ptr+1, ... and wrapping modulo NCH.
REQ-019 On a free cycle with any req set, these actions SHALL occur together:
- grant[winner]=1 in that cycle;
- out_data, out_chan and out_valid=1 registered at the next edge (1-cycle latency).
REQ-020 Data selected: if load[winner]=1 in the grant cycle, out_data SHALL take din slice winner (write-through); otherwise it SHALL take hold[winner].
REQ-021 ptr SHALL update to (winner+1) mod NCH only on a grant, in both modes; it SHALL never change without a grant.
REQ-022 Free cycle with no req set: grant SHALL be all-zero and out_valid SHALL be 0 at the next edge.
REQ-023 Stall (out_valid=1 and out_ready=0): grant SHALL be 0, and out_data, out_chan and out_valid SHALL hold.
REQ-024 Back-to-back: with out_ready held at 1 and requests present, one word SHALL be granted per cycle with no bubble.
REQ-025 A requester SHALL be allowed to keep req high after its grant; it then competes again the next cycle.
REQ-026 An rr_mode change SHALL take effect at the next arbitration, and ptr SHALL be preserved across the change.
REQ-027 grant SHALL have at most one bit set in every cycle.

Reset
REQ-028 While reset=1 at an edge, the block SHALL clear:
- every hold[i], out_data, out_chan and ptr to 0;
- out_valid to 0.
REQ-029 While reset=1, grant SHALL be all-zero regardless of req.
REQ-030 Reset SHALL take priority over load and over arbitration in the same cycle.
REQ-031 A word pending in the output register when reset asserts SHALL be discarded.

Structure
REQ-032 Package prio_arb_pkg SHALL hold:
- mode constants MODE_FIXED=0 and MODE_RR=1;
- the clog2 function used for CW.
REQ-033 Sub-module rr_pick SHALL be combinational, taking req and start pointer and returning a one-hot winner plus its index.
REQ-034 Fixed mode SHALL reuse rr_pick with start pointer 0.

Verification (NCH=4, WIDTH=4)
REQ-035 Reset: hold reset=1 for 2 cycles with req=4'hF -> grant=0 and out_valid=0; after release, out_data=0 and ptr=0.
REQ-036 Fixed priority, channels loaded 3, 5, 9, C:
- req=4'b1010, out_ready=1 -> grant=4'b0010;
- next cycle: out_data=5, out_chan=1.
REQ-037 Round-robin: req=4'hF held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-038 Stall:
- out_ready=0 for 3 cycles -> out_data stable and grant=0;
- out_ready=1 -> next grant issues in the same cycle.
REQ-039 Write-through: load[2]=1 with din slice 2=7 and grant to channel 2 in the same cycle -> out_data=7 next cycle, and hold[2]=7.
REQ-040 Reset mid-stream: reset=1 while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, and the first post-reset round-robin grant goes to the lowest requesting index.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared constants and helpers for the priority/round-robin arbitrating mux.
package prio_arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

endpackage

// File: rtl/prio_arb_mux_rr_pick.sv
// Combinational rotating picker: first set request at or after the start index.
module rr_pick
   import prio_arb_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  start,
   output logic [NCH-1:0] onehot,
   output logic [CW-1:0]  idx,
   output logic           any
);

   int pos;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      pos    = 0;
      for (int k = 0; k < NCH; k++) begin
         pos = (int'(start) + k) % NCH;
         if (!any && req[pos]) begin
            any         = 1'b1;
            onehot[pos] = 1'b1;
            idx         = CW'(pos);
         end
      end
   end

endmodule

// File: rtl/prio_arb_mux.sv
// N-channel hold-register mux with fixed or round-robin arbitration into a
// single registered output stage with ready/valid backpressure.
module prio_arb_mux
   import prio_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NCH   = 4,
   localparam int CW   = clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       req,
   input  logic [NCH-1:0]       load,
   input  logic [NCH*WIDTH-1:0] din,
   input  logic                 rr_mode,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [CW-1:0]        out_chan,
   output logic [NCH-1:0]       grant
);

   logic [WIDTH-1:0] hold [NCH];
   logic [CW-1:0]    ptr;
   logic [CW-1:0]    start;
   logic [NCH-1:0]   win;
   logic [CW-1:0]    win_idx;
   logic             win_any;
   logic             free;
   logic [WIDTH-1:0] sel_data;
   logic [CW-1:0]    ptr_next;

   // Fixed priority is just the rotating search anchored at channel 0.
   assign start = (rr_mode == MODE_RR) ? ptr : '0;

   rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
      .req    (req),
      .start  (start),
      .onehot (win),
      .idx    (win_idx),
      .any    (win_any)
   );

   assign free     = !out_valid || out_ready;
   assign grant    = (!reset && free) ? win : '0;
   // A word loaded in the grant cycle bypasses its hold register.
   assign sel_data = load[win_idx] ? din[win_idx*WIDTH +: WIDTH] : hold[win_idx];
   assign ptr_next = (win_idx == CW'(NCH-1)) ? '0 : win_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) hold[i] <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else begin
         for (int i = 0; i < NCH; i++)
            if (load[i]) hold[i] <= din[i*WIDTH +: WIDTH];
         if (free) begin
            out_valid <= win_any;
            if (win_any) begin
               out_data <= sel_data;
               out_chan <= win_idx;
               ptr      <= ptr_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_prio_arb_mux.sv
// Directed bench for prio_arb_mux at NCH=4, WIDTH=4.
module tb_prio_arb_mux;

   localparam int WIDTH = 4;
   localparam int NCH   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    req;
   logic [NCH-1:0]    load;
   logic [NCH*WIDTH-1:0] din;
   logic              rr_mode;
   logic              out_ready;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic [1:0]        out_chan;
   logic [NCH-1:0]    grant;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] ch_val [4];

   prio_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .load      (load),
      .din       (din),
      .rr_mode   (rr_mode),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .grant     (grant)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      ch_val[0] = 4'h3; ch_val[1] = 4'h5; ch_val[2] = 4'h9; ch_val[3] = 4'hC;
      reset = 1'b1; req = 4'hF; load = '0; din = '0; rr_mode = 1'b0; out_ready = 1'b1;

      // reset held for two edges with all requests up
      #1 chk("rst_grant0", 16'(grant), 16'h0);
      tick;
      chk("rst_valid1", 16'(out_valid), 16'h0);
      chk("rst_grant1", 16'(grant), 16'h0);
      tick;
      chk("rst_valid2", 16'(out_valid), 16'h0);
      reset = 1'b0; req = 4'h0;
      #1 chk("idle_grant", 16'(grant), 16'h0);
      tick;
      chk("post_rst_data", 16'(out_data), 16'h0);
      chk("post_rst_chan", 16'(out_chan), 16'h0);
      chk("post_rst_valid", 16'(out_valid), 16'h0);

      // load hold registers 3,5,9,C
      load = 4'hF; din = {4'hC, 4'h9, 4'h5, 4'h3};
      tick;
      load = 4'h0; din = '0;

      // fixed priority
      rr_mode = 1'b0; req = 4'b1010;
      #1 chk("fix_grant", 16'(grant), 16'b0010);
      tick;
      chk("fix_data", 16'(out_data), 16'h5);
      chk("fix_chan", 16'(out_chan), 16'h1);
      chk("fix_valid", 16'(out_valid), 16'h1);
      req = 4'b1000;
      #1 chk("fix_grant3", 16'(grant), 16'b1000);
      tick;
      chk("fix_data3", 16'(out_data), 16'hC);
      chk("fix_chan3", 16'(out_chan), 16'h3);

      // round-robin, ptr wrapped to 0 by the channel-3 grant
      rr_mode = 1'b1; req = 4'hF;
      #1 chk("rr_grant_first", 16'(grant), 16'b0001);
      for (int k = 0; k < 5; k++) begin
         tick;
         chk($sformatf("rr_chan%0d", k), 16'(out_chan), 16'(k % 4));
         chk($sformatf("rr_data%0d", k), 16'(out_data), 16'(ch_val[k % 4]));
         chk($sformatf("rr_valid%0d", k), 16'(out_valid), 16'h1);
         chk($sformatf("rr_grant%0d", k), 16'(grant), 16'(1 << ((k + 1) % 4)));
      end

      // stall for three cycles, then release
      out_ready = 1'b0;
      #1 chk("stall_grant", 16'(grant), 16'h0);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("stall_data%0d", k), 16'(out_data), 16'h3);
         chk($sformatf("stall_chan%0d", k), 16'(out_chan), 16'h0);
         chk($sformatf("stall_valid%0d", k), 16'(out_valid), 16'h1);
         chk($sformatf("stall_grant%0d", k), 16'(grant), 16'h0);
      end
      out_ready = 1'b1;
      #1 chk("unstall_grant", 16'(grant), 16'b0010);
      tick;
      chk("unstall_chan", 16'(out_chan), 16'h1);
      chk("unstall_data", 16'(out_data), 16'h5);

      // write-through on channel 2
      req = 4'b0100; load = 4'b0100; din = {4'hC, 4'h7, 4'h9, 4'h3};
      #1 chk("wt_grant", 16'(grant), 16'b0100);
      tick;
      chk("wt_data", 16'(out_data), 16'h7);
      chk("wt_chan", 16'(out_chan), 16'h2);
      load = 4'h0; req = 4'h0; din = '0;
      #1 chk("wt_idle_grant", 16'(grant), 16'h0);
      tick;
      chk("wt_idle_valid", 16'(out_valid), 16'h0);
      rr_mode = 1'b0; req = 4'b0100;
      #1 chk("hold2_grant", 16'(grant), 16'b0100);
      tick;
      chk("hold2_data", 16'(out_data), 16'h7);

      // reset while a stalled word is pending; ptr is 3 beforehand
      out_ready = 1'b0; req = 4'hF;
      tick;
      chk("pre_rst_valid", 16'(out_valid), 16'h1);
      reset = 1'b1;
      #1 chk("mid_rst_grant", 16'(grant), 16'h0);
      tick;
      chk("mid_rst_valid", 16'(out_valid), 16'h0);
      chk("mid_rst_data", 16'(out_data), 16'h0);
      reset = 1'b0; rr_mode = 1'b1; req = 4'b1001; out_ready = 1'b1;
      #1 chk("post_mid_grant", 16'(grant), 16'b0001);
      tick;
      chk("post_mid_chan", 16'(out_chan), 16'h0);
      chk("post_mid_data", 16'(out_data), 16'h0);
      chk("post_mid_valid", 16'(out_valid), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
